// File: rtl/rect_fill_engine.sv
// -----------------------------------------------------------------------------
// rect_fill_engine
//   Writer side of the 160x120 video memory. Accepts rectangle-fill commands
//   and emits one pixel write per clock into the VGA controller's write port,
//   row-major, left to right then top to bottom. Coordinates are clamped to the
//   screen. An empty rectangle (x0 > x1 or y0 > y1 after clamping) completes
//   with no writes.
//
// Ports
//   clk, rst                    system clock, synchronous active-high reset
//   cmd_valid / cmd_ready       command handshake (ready only in IDLE)
//   cmd_x0/y0/x1/y1             inclusive rectangle corners
//   cmd_color                   fill colour
//   data_addr/data_in           write address (y*SCREEN_W + x) and pixel data
//   write_enable                one pixel per high cycle
//   busy                        high while filling and in the done cycle
//   done                        one-cycle completion pulse
// -----------------------------------------------------------------------------
module rect_fill_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int ADDR_W   = 15,
    parameter int COLOR_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_x0,
    input  logic [6:0]         cmd_y0,
    input  logic [7:0]         cmd_x1,
    input  logic [6:0]         cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic [ADDR_W-1:0]  data_addr,
    output logic [COLOR_W-1:0] data_in,
    output logic               write_enable,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0]        X_MAX  = 8'(SCREEN_W - 1);
    localparam logic [6:0]        Y_MAX  = 7'(SCREEN_H - 1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(SCREEN_W);

    // y * SCREEN_W as a sum of shifted copies of y, one per set bit of the
    // constant stride; for 160 this reduces to (y<<7) + (y<<5).
    function automatic logic [ADDR_W-1:0] row_of(input logic [6:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            if (((SCREEN_W >> b) & 1) != 0) acc = acc + (ADDR_W'(y) << b);
        end
        return acc;
    endfunction

    logic [1:0]         state_q,    state_d;
    logic [7:0]         x0_q,       x0_d;
    logic [7:0]         x1_q,       x1_d;
    logic [6:0]         y1_q,       y1_d;
    logic [7:0]         cur_x_q,    cur_x_d;
    logic [6:0]         cur_y_q,    cur_y_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [COLOR_W-1:0] color_q,    color_d;

    logic [7:0] cx0, cx1;
    logic [6:0] cy0, cy1;

    assign cx0 = (cmd_x0 > X_MAX) ? X_MAX : cmd_x0;
    assign cx1 = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
    assign cy0 = (cmd_y0 > Y_MAX) ? Y_MAX : cmd_y0;
    assign cy1 = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;

    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        row_base_d = row_base_q;
        color_d    = color_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cx0 > cx1 || cy0 > cy1) begin
                        // Empty: nothing visible changes, address/data hold.
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_FILL;
                        x0_d       = cx0;
                        x1_d       = cx1;
                        y1_d       = cy1;
                        cur_x_d    = cx0;
                        cur_y_d    = cy0;
                        row_base_d = row_of(cy0);
                        color_d    = cmd_color;
                    end
                end
            end
            S_FILL: begin
                if (cur_x_q == x1_q) begin
                    if (cur_y_q == y1_q) begin
                        // Counters freeze on the last pixel so data_addr keeps
                        // showing it after the fill ends.
                        state_d = S_DONE;
                    end else begin
                        cur_x_d    = x0_q;
                        cur_y_d    = cur_y_q + 7'd1;
                        row_base_d = row_base_q + STRIDE;
                    end
                end else begin
                    cur_x_d = cur_x_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; all registers are reset so data_addr and
    // data_in start at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            row_base_q <= '0;
            color_q    <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            row_base_q <= row_base_d;
            color_q    <= color_d;
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign write_enable = (state_q == S_FILL);
    assign done         = (state_q == S_DONE);
    assign busy         = (state_q == S_FILL) || (state_q == S_DONE);
    assign data_addr    = row_base_q + ADDR_W'(cur_x_q);
    assign data_in      = color_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_rect_fill_engine
//   Directed self-checking bench for rect_fill_engine: single pixel, right-edge
//   rectangle, full-screen clear against a memory model, clamping, empty
//   rectangle, reset mid-fill and recovery.
// -----------------------------------------------------------------------------
module tb_rect_fill_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x0;
    logic [6:0]  cmd_y0;
    logic [7:0]  cmd_x1;
    logic [6:0]  cmd_y1;
    logic [2:0]  cmd_color;
    logic [14:0] data_addr;
    logic [2:0]  data_in;
    logic        write_enable;
    logic        busy;
    logic        done;

    rect_fill_engine dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_x0       (cmd_x0),
        .cmd_y0       (cmd_y0),
        .cmd_x1       (cmd_x1),
        .cmd_y1       (cmd_y1),
        .cmd_color    (cmd_color),
        .data_addr    (data_addr),
        .data_in      (data_in),
        .write_enable (write_enable),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [14:0] waddr_q[$];
    logic [2:0]  wdata_q[$];
    logic [2:0]  mem  [0:19199];
    int          wcnt [0:19199];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Presents one command on a falling edge and returns at the falling edge
    // after the accept edge, i.e. in the cycle the first write should appear.
    task automatic issue(input logic [7:0] x0, input logic [6:0] y0,
                         input logic [7:0] x1, input logic [6:0] y1,
                         input logic [2:0] color);
        @(negedge clk);
        check("ready_before_cmd", cmd_ready, 1);
        cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = color;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        // Command fields need not stay stable after acceptance.
        cmd_x0 = 8'($urandom); cmd_y0 = 7'($urandom);
        cmd_x1 = 8'($urandom); cmd_y1 = 7'($urandom);
        cmd_color = 3'($urandom);
    endtask

    // Issues a command and records every write until done. done_at is the
    // number of cycles from the first post-accept cycle to the done cycle,
    // which equals the write count when there are no bubbles.
    task automatic run_cmd(input logic [7:0] x0, input logic [6:0] y0,
                           input logic [7:0] x1, input logic [6:0] y1,
                           input logic [2:0] color, input int budget,
                           output int nw, output int done_at);
        bit got_done;
        waddr_q.delete();
        wdata_q.delete();
        nw       = 0;
        done_at  = -1;
        got_done = 1'b0;
        issue(x0, y0, x1, y1, color);
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                got_done = 1'b1;
                done_at  = c;
                break;
            end
            if (write_enable) begin
                waddr_q.push_back(data_addr);
                wdata_q.push_back(data_in);
                if (data_addr < 15'd19200) begin
                    mem[data_addr]  = data_in;
                    wcnt[data_addr] = wcnt[data_addr] + 1;
                end
                nw++;
            end
            @(negedge clk);
        end
        check("done_seen", 32'(got_done), 1);
        check("we_low_in_done", write_enable, 0);
        check("ready_low_in_done", cmd_ready, 0);
        check("no_bubbles", done_at, nw);
        @(negedge clk);
        check("ready_after_done", cmd_ready, 1);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int nw;
        int done_at;
        int bad_cnt;
        int nonzero;
        int exp_addr [4];

        rst = 1'b1; cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", write_enable, 0);
        check("rst_addr", data_addr, 0);
        check("rst_data", data_in, 0);
        rst = 1'b0;

        // 1. Single pixel (5,7): 7*160+5 = 1125, visible right after accept.
        issue(8'd5, 7'd7, 8'd5, 7'd7, 3'b101);
        check("t1_we", write_enable, 1);
        check("t1_addr", data_addr, 1125);
        check("t1_data", data_in, 5);
        check("t1_busy", busy, 1);
        check("t1_ready_fill", cmd_ready, 0);
        @(negedge clk);
        check("t1_we_off", write_enable, 0);
        check("t1_done", done, 1);
        check("t1_busy_done", busy, 1);
        @(negedge clk);
        check("t1_done_off", done, 0);
        check("t1_ready", cmd_ready, 1);
        check("t1_busy_off", busy, 0);
        check("t1_addr_hold", data_addr, 1125);

        // 2. Right edge two rows: 158,159,318,319.
        run_cmd(8'd158, 7'd0, 8'd159, 7'd1, 3'b010, 20, nw, done_at);
        check("t2_count", nw, 4);
        exp_addr = '{158, 159, 318, 319};
        for (int i = 0; i < 4 && i < nw; i++) begin
            check("t2_addr", waddr_q[i], exp_addr[i]);
            check("t2_data", wdata_q[i], 3'b010);
        end

        // 3. Full clear over a memory model pre-filled with non-zero colour.
        for (int i = 0; i < 19200; i++) begin
            mem[i]  = 3'b111;
            wcnt[i] = 0;
        end
        run_cmd(8'd0, 7'd0, 8'd159, 7'd119, 3'b000, 20000, nw, done_at);
        check("t3_count", nw, 19200);
        check("t3_first_addr", (nw > 0) ? waddr_q[0] : 15'h7fff, 0);
        check("t3_last_addr", (nw > 0) ? waddr_q[nw-1] : 15'h7fff, 19199);
        bad_cnt = 0;
        nonzero = 0;
        for (int i = 0; i < 19200; i++) begin
            if (wcnt[i] != 1) bad_cnt++;
            if (mem[i] != 3'b000) nonzero++;
        end
        check("t3_each_once", bad_cnt, 0);
        check("t3_mem_zero", nonzero, 0);
        bad_cnt = 0;
        for (int i = 1; i < nw; i++) if (waddr_q[i] != waddr_q[i-1] + 15'd1) bad_cnt++;
        check("t3_row_major", bad_cnt, 0);

        // 4. Clamp to the bottom-right pixel.
        run_cmd(8'd159, 7'd119, 8'd200, 7'd127, 3'b110, 20, nw, done_at);
        check("t4_count", nw, 1);
        check("t4_addr", (nw > 0) ? waddr_q[0] : 15'h7fff, 19199);
        check("t4_data", (nw > 0) ? wdata_q[0] : 3'b000, 3'b110);

        // 5. Empty rectangle: done right after accept, outputs hold.
        issue(8'd10, 7'd3, 8'd9, 7'd5, 3'b011);
        check("t5_we", write_enable, 0);
        check("t5_done", done, 1);
        check("t5_busy", busy, 1);
        check("t5_addr_hold", data_addr, 19199);
        check("t5_data_hold", data_in, 3'b110);
        @(negedge clk);
        check("t5_busy_off", busy, 0);
        check("t5_done_off", done, 0);
        check("t5_ready", cmd_ready, 1);

        // 6. Reset after the 10th write of a 20x20 fill.
        issue(8'd0, 7'd0, 8'd19, 7'd19, 3'b001);
        nw = 0;
        for (int c = 0; c < 40 && nw < 10; c++) begin
            if (write_enable) nw++;
            if (nw < 10) @(negedge clk);
        end
        check("t6_ten_writes", nw, 10);
        check("t6_tenth_addr", data_addr, 9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_we_off", write_enable, 0);
        check("t6_no_done", done, 0);
        check("t6_ready", cmd_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_addr_rst", data_addr, 0);
        nw = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (write_enable || done) nw++;
        end
        check("t6_stays_idle", nw, 0);
        run_cmd(8'd3, 7'd2, 8'd3, 7'd2, 3'b111, 20, nw, done_at);
        check("t6_after_count", nw, 1);
        check("t6_after_addr", (nw > 0) ? waddr_q[0] : 15'h7fff, 323);
        check("t6_after_data", (nw > 0) ? wdata_q[0] : 3'b000, 3'b111);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
